// File: rtl/mouse_packet_fifo_io.sv
// PS/2 mouse packet assembler with a packet FIFO, an 8-byte bus register window and an interrupt handshake.
// Optional byte-0 sync-bit filtering is enabled by defining MOUSE_SYNC_CHECK_EN.
module mouse_packet_fifo_io #(
  parameter logic [7:0] BASE_ADDR  = 8'hA0,
  parameter int         PKT_BYTES  = 3,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       BYTE_ERR,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, SERVICED = 2'd2} state_t;

  logic [1:0]    r_idx;
  logic [31:0]   r_asm;
  logic          r_push_pend;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [CW-1:0] r_wr;
  logic [CW-1:0] r_rd;
  logic          r_ovf;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_raise;

  logic          w_byte_ok;
  logic [31:0]   w_asm_nxt;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic [7:0]    w_off;
  logic          w_in_win;
  logic          w_pop_wr;
  logic          w_pop;
  logic          w_ovf_clr;
  logic [31:0]   w_head;
  logic [7:0]    w_status;
  logic [7:0]    w_rd_data;

`ifdef MOUSE_SYNC_CHECK_EN
  // Byte 0 of every packet carries a 1 in bit 3; anything else is line noise.
  assign w_byte_ok = BYTE_VALID && !((r_idx == 2'd0) && !BYTE_IN[3]);
`else
  assign w_byte_ok = BYTE_VALID;
`endif

  assign w_count   = r_wr - r_rd;
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push    = r_push_pend && !w_full && !RESET;
  assign w_off     = BUS_ADDR - BASE_ADDR;
  assign w_in_win  = (w_off[7:3] == 5'd0);
  assign w_pop_wr  = BUS_WE && w_in_win && (w_off == 8'd5) && !RESET;
  assign w_pop     = w_pop_wr && !w_empty;
  assign w_ovf_clr = BUS_WE && w_in_win && (w_off == 8'd4) && BUS_DATA[7];
  assign w_head    = r_mem[r_rd[AW-1:0]];
  assign w_status  = {r_ovf, w_empty, w_full, 5'(w_count)};
  assign BUS_DATA  = (!BUS_WE && w_in_win) ? w_rd_data : 8'hzz;

  // Insert the incoming byte into the packet being assembled.
  always_comb begin
    w_asm_nxt = r_asm;
    w_asm_nxt[{r_idx, 3'b000} +: 8] = BYTE_IN;
  end

  // Byte index and packet assembly; a completed packet is pushed on the following edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx       <= 2'd0;
      r_asm       <= 32'd0;
      r_push_pend <= 1'b0;
    end else begin
      r_push_pend <= 1'b0;
      if (BYTE_ERR) begin
        r_idx <= 2'd0;
      end else if (w_byte_ok) begin
        r_asm <= w_asm_nxt;
        if (r_idx == 2'(PKT_BYTES - 1)) begin
          r_idx       <= 2'd0;
          r_push_pend <= 1'b1;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  // Packet storage.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= r_asm;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (r_push_pend && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  // Register window read mux.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_off == 8'd4) begin
      w_rd_data = w_status;
    end else if ((w_off < 8'(PKT_BYTES)) && !w_empty) begin
      w_rd_data = w_head[{w_off[1:0], 3'b000} +: 8];
    end else begin
      w_rd_data = 8'h00;
    end
  end

  // Interrupt FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     w_state_nxt = w_empty ? IDLE : PEND;
      PEND:     w_state_nxt = BUS_INTERRUPT_ACK ? SERVICED : PEND;
      SERVICED: w_state_nxt = w_pop_wr ? IDLE : SERVICED;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Interrupt FSM state and registered request output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_raise <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_raise <= (w_state_nxt == PEND);
    end
  end

  assign BUS_INTERRUPT_RAISE = r_raise;

endmodule

// File: tb/tb_mouse_packet_fifo_io.sv
// Directed bench for mouse_packet_fifo_io: a standard 3-byte instance and a 4-byte wheel instance.
module tb_mouse_packet_fifo_io;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic       valid;
  logic       valid4;
  logic       err;
  logic       ack;
  logic       oe;
  logic [7:0] addr;
  logic [7:0] byte_in;
  logic [7:0] drv;
  logic [7:0] d;
  wire  [7:0] bus3;
  wire  [7:0] bus4;
  wire        raise3;
  wire        raise4;
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign bus3 = oe ? drv : 8'hzz;
  assign bus4 = oe ? drv : 8'hzz;

  mouse_packet_fifo_io #(.BASE_ADDR(8'hA0), .PKT_BYTES(3), .FIFO_DEPTH(4)) dut3 (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus3), .BUS_ADDR(addr), .BUS_WE(we),
    .BYTE_IN(byte_in), .BYTE_VALID(valid), .BYTE_ERR(err),
    .BUS_INTERRUPT_RAISE(raise3), .BUS_INTERRUPT_ACK(ack));

  mouse_packet_fifo_io #(.BASE_ADDR(8'hA0), .PKT_BYTES(4), .FIFO_DEPTH(4)) dut4 (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus4), .BUS_ADDR(addr), .BUS_WE(we),
    .BYTE_IN(byte_in), .BYTE_VALID(valid4), .BYTE_ERR(err),
    .BUS_INTERRUPT_RAISE(raise4), .BUS_INTERRUPT_ACK(ack));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    byte_in = b; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
  endtask

  task automatic rd3(input logic [7:0] a, output logic [7:0] v);
    addr = a; we = 1'b0;
    #1 v = bus3;
  endtask

  task automatic rd4(input logic [7:0] a, output logic [7:0] v);
    addr = a; we = 1'b0;
    #1 v = bus4;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    addr = a; drv = v; oe = 1'b1; we = 1'b1;
    @(negedge clk);
    we = 1'b0; oe = 1'b0; addr = 8'h00;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; valid = 1'b0; valid4 = 1'b0; err = 1'b0; ack = 1'b0;
    oe = 1'b0; addr = 8'h00; byte_in = 8'h00; drv = 8'h00;
    tick(3);
    chk("reset_raise", {7'd0, raise3}, 8'h00);
    rd3(8'hA4, d); chk("reset_status", d, 8'h40);
    rst = 1'b0;
    tick(1);

    // Basic packet; one queued packet: not full, not empty, count 1.
    send(8'h0A); send(8'h28); send(8'h1E);
    tick(1);
    rd3(8'hA4, d); chk("basic_status", d, 8'h01);
    tick(1);
    chk("basic_raise", {7'd0, raise3}, 8'h01);
    rd3(8'hA0, d); chk("basic_b0", d, 8'h0A);
    rd3(8'hA1, d); chk("basic_b1", d, 8'h28);
    rd3(8'hA2, d); chk("basic_b2", d, 8'h1E);
    rd3(8'hA3, d); chk("basic_a3_zero", d, 8'h00);
    rd3(8'hA6, d); chk("basic_a6_zero", d, 8'h00);

    // Interrupt handshake.
    tick(1);
    pulse_ack();
    chk("ack_drops_raise", {7'd0, raise3}, 8'h00);
    wr(8'hA5, 8'h00);
    rd3(8'hA4, d); chk("pop_status", d, 8'h40);
    rd3(8'hA0, d); chk("empty_head_zero", d, 8'h00);
    tick(2);
    chk("raise_stays_low", {7'd0, raise3}, 8'h00);

    // Overflow: five packets into four slots.
    for (int p = 0; p < 5; p++) begin
      send(8'h08 + 8'(p)); send(8'h21 + 8'(p)); send(8'h31 + 8'(p));
    end
    tick(2);
    rd3(8'hA4, d); chk("ovf_status", d, 8'hA4);
    rd3(8'hA0, d); chk("ovf_head_b0", d, 8'h08);
    rd3(8'hA2, d); chk("ovf_head_b2", d, 8'h31);
    wr(8'hA4, 8'h80);
    rd3(8'hA4, d); chk("ovf_clear", d, 8'h24);
    chk("ovf_raise", {7'd0, raise3}, 8'h01);

    // Re-raise after servicing while packets remain.
    pulse_ack();
    wr(8'hA5, 8'h00);
    chk("rearm_idle_low", {7'd0, raise3}, 8'h00);
    rd3(8'hA0, d); chk("second_head", d, 8'h09);
    tick(1);
    chk("rearm_raise", {7'd0, raise3}, 8'h01);
    wr(8'hA5, 8'h00); wr(8'hA5, 8'h00); wr(8'hA5, 8'h00);
    rd3(8'hA4, d); chk("drained", d, 8'h40);
    pulse_ack();
    wr(8'hA5, 8'h00);
    rd3(8'hA4, d); chk("empty_pop_ignored", d, 8'h40);
    tick(2);
    chk("drained_raise_low", {7'd0, raise3}, 8'h00);

    // Error resync; error wins over a simultaneous valid byte.
    send(8'h0A); send(8'h28);
    err = 1'b1; byte_in = 8'h77; valid = 1'b1;
    @(negedge clk);
    err = 1'b0; valid = 1'b0;
    send(8'h09); send(8'h05); send(8'h06);
    tick(2);
    rd3(8'hA4, d); chk("resync_status", d, 8'h01);
    rd3(8'hA0, d); chk("resync_b0", d, 8'h09);
    rd3(8'hA1, d); chk("resync_b1", d, 8'h05);
    rd3(8'hA2, d); chk("resync_b2", d, 8'h06);
    pulse_ack();
    wr(8'hA5, 8'h00);

    // Byte-0 sync check.
    send(8'h00); send(8'h08); send(8'h01); send(8'h02);
    tick(2);
    rd3(8'hA4, d); chk("sync_status", d, 8'h01);
`ifdef MOUSE_SYNC_CHECK_EN
    rd3(8'hA0, d); chk("sync_b0", d, 8'h08);
    rd3(8'hA1, d); chk("sync_b1", d, 8'h01);
    rd3(8'hA2, d); chk("sync_b2", d, 8'h02);
`else
    rd3(8'hA0, d); chk("sync_b0", d, 8'h00);
    rd3(8'hA1, d); chk("sync_b1", d, 8'h08);
    rd3(8'hA2, d); chk("sync_b2", d, 8'h01);
`endif
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;

    // Reset mid-assembly with a packet already queued.
    send(8'h08); send(8'h01);
    rst = 1'b1;
    tick(1);
    chk("rst_raise_low", {7'd0, raise3}, 8'h00);
    rd3(8'hA4, d); chk("rst_status", d, 8'h40);
    rst = 1'b0;
    send(8'h0A); send(8'h28); send(8'h1E);
    tick(2);
    rd3(8'hA4, d); chk("post_rst_status", d, 8'h01);
    rd3(8'hA0, d); chk("post_rst_b0", d, 8'h0A);
    rd3(8'hA2, d); chk("post_rst_b2", d, 8'h1E);

    // Wheel mode: four-byte packets.
    send4(8'h08); send4(8'h01); send4(8'h02); send4(8'hFF);
    tick(2);
    rd4(8'hA4, d); chk("wheel_status", d, 8'h01);
    rd4(8'hA0, d); chk("wheel_b0", d, 8'h08);
    rd4(8'hA3, d); chk("wheel_b3", d, 8'hFF);
    chk("wheel_raise", {7'd0, raise4}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
